// File: rtl/vector_seq.sv
// Exhaustive 3-input stimulus sequencer: walks the eight {x,y,z} vectors in a
// fixed order, holds each for HOLD cycles and captures the response into truth_tbl.
module vector_seq #(
    parameter int HOLD = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_out,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       busy,
    output logic       done,
    output logic [2:0] step,
    output logic [7:0] truth_tbl
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        FIN   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

    state_t     state;
    logic [7:0] hold_cnt;

    // Vector order chosen so consecutive vectors differ mostly in one bit.
    function automatic logic [2:0] vec_of(input logic [2:0] s);
        case (s)
            3'd0:    vec_of = 3'b000;
            3'd1:    vec_of = 3'b100;
            3'd2:    vec_of = 3'b110;
            3'd3:    vec_of = 3'b010;
            3'd4:    vec_of = 3'b001;
            3'd5:    vec_of = 3'b101;
            3'd6:    vec_of = 3'b111;
            default: vec_of = 3'b011;
        endcase
    endfunction

    // NOTE: every flop here, including the captured truth table, is cleared by
    // the async reset so an aborted sweep leaves no stale partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_cnt  <= 8'd0;
            step      <= 3'd0;
            x         <= 1'b0;
            y         <= 1'b0;
            z         <= 1'b0;
            truth_tbl <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments, so reads of step/x/y/z below see
            // the values from before this edge.
            case (state)
                IDLE: begin
                    step        <= 3'd0;
                    hold_cnt    <= 8'd0;
                    {x, y, z}   <= 3'b000;
                    if (start) begin
                        state     <= DRIVE;
                        truth_tbl <= 8'h00;
                        {x, y, z} <= vec_of(3'd0);
                    end
                end
                DRIVE: begin
                    if (hold_cnt == HOLD_LAST) begin
                        truth_tbl[{x, y, z}] <= dut_out;
                        hold_cnt             <= 8'd0;
                        if (step == 3'd7) begin
                            state     <= FIN;
                            {x, y, z} <= 3'b000;
                        end else begin
                            step      <= step + 3'd1;
                            {x, y, z} <= vec_of(step + 3'd1);
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    step  <= 3'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == DRIVE);
    assign done = (state == FIN);

endmodule

// File: tb/tb_vector_seq.sv
// Directed bench for vector_seq: HOLD=5 and HOLD=1 instances driven against
// simple gate models, checking vector order, timing, capture and reset.
module tb_vector_seq;

    logic clk = 1'b0;
    logic rst_n;
    logic start5, start1;
    logic dout5, dout1;
    logic x5, y5, z5, busy5, done5;
    logic x1, y1, z1, busy1, done1;
    logic [2:0] step5, step1;
    logic [7:0] tbl5, tbl1;
    int mode;
    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0] order_tbl [8] = '{3'b000, 3'b100, 3'b110, 3'b010,
                                  3'b001, 3'b101, 3'b111, 3'b011};

    always #5 clk = ~clk;

    function automatic logic gate(input int m, input logic a, b, c);
        case (m)
            0:       gate = a & b;
            1:       gate = a | b;
            2:       gate = ~a;
            3:       gate = c;
            default: gate = 1'b0;
        endcase
    endfunction

    assign dout5 = gate(mode, x5, y5, z5);
    assign dout1 = gate(mode, x1, y1, z1);

    vector_seq #(.HOLD(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .dut_out(dout5),
        .x(x5), .y(y5), .z(z5), .busy(busy5), .done(done5),
        .step(step5), .truth_tbl(tbl5)
    );

    vector_seq #(.HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dut_out(dout1),
        .x(x1), .y(y1), .z(z1), .busy(busy1), .done(done1),
        .step(step1), .truth_tbl(tbl1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Packed snapshot {xyz, busy, done, step, truth_tbl} of one instance.
    function automatic logic [15:0] obs(input int h);
        if (h == 1) obs = {x1, y1, z1, busy1, done1, step1, tbl1};
        else        obs = {x5, y5, z5, busy5, done5, step5, tbl5};
    endfunction

    task automatic set_start(input int h, input logic v);
        if (h == 1) start1 = v;
        else        start5 = v;
    endtask

    // smode: 0 = single start pulse, 1 = start held high, 2 = extra pulse in step 5.
    task automatic sweep(input int h, input int smode, input logic [7:0] exp_tbl, input string tag);
        logic [15:0] o;
        set_start(h, 1'b1);
        @(posedge clk); #1;
        if (smode != 1) set_start(h, 1'b0);
        for (int i = 0; i < 8 * h; i++) begin
            o = obs(h);
            check({tag, "_vec"}, 32'(o[15:13]), 32'(order_tbl[i / h]));
            check({tag, "_busy"}, 32'(o[12:11]), 32'(2'b10));
            check({tag, "_step"}, 32'(o[10:8]), 32'(i / h));
            if (smode == 2) set_start(h, (i == 5 * h + 1));
            @(posedge clk); #1;
        end
        o = obs(h);
        check({tag, "_fin_ctl"}, 32'(o[15:8]), 32'({3'b000, 1'b0, 1'b1, 3'd7}));
        check({tag, "_tbl"}, 32'(o[7:0]), 32'(exp_tbl));
        @(posedge clk); #1;
        o = obs(h);
        check({tag, "_idle"}, 32'(o[15:8]), 32'h0);
        check({tag, "_tbl_hold"}, 32'(o[7:0]), 32'(exp_tbl));
    endtask

    initial begin
        int ndone;
        rst_n  = 1'b0;
        start5 = 1'b0;
        start1 = 1'b0;
        mode   = 0;
        #1;
        check("reset5", 32'(obs(5)), 32'h0);
        check("reset1", 32'(obs(1)), 32'h0);
        #11 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_start", 32'(obs(5)), 32'h0);

        mode = 0; sweep(5, 0, 8'hC0, "and");
        mode = 1; sweep(5, 0, 8'hFC, "or");
        mode = 2; sweep(5, 0, 8'h0F, "notx");
        mode = 3; sweep(1, 0, 8'hAA, "h1_z");
        mode = 0; sweep(5, 2, 8'hC0, "glitch");

        // start held high: FIN ignores it, the next IDLE edge starts afresh.
        mode = 1; sweep(5, 1, 8'hFC, "held");
        @(posedge clk); #1;
        check("held_restart_busy", 32'(busy5), 32'h1);
        check("held_restart_tbl", 32'(tbl5), 32'h00);
        check("held_restart_step", 32'(step5), 32'h0);
        start5 = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("held_second_done", 32'(done5), 32'h1);
        check("held_second_tbl", 32'(tbl5), 32'hFC);
        @(posedge clk); #1;

        // Reset mid-sweep during step 3.
        mode = 1;
        start5 = 1'b1;
        @(posedge clk); #1;
        start5 = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        check("rst_pre_step", 32'(step5), 32'h3);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", 32'(obs(5)), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done5 || busy5) ndone++;
        end
        check("rst_no_activity", 32'(ndone), 32'h0);
        check("rst_tbl", 32'(tbl5), 32'h00);
        mode = 2; sweep(5, 0, 8'h0F, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
